// File: rtl/pdm_pcm_decoder.sv
// rtl/pdm_pcm_decoder.sv - 3rd-order CIC decimator turning a 1-bit PDM stream into signed PCM
// Optional 2-flop input synchronizer enabled by defining PDM_PCM_DECODER_INSYNC_EN.
module pdm_pcm_decoder #(
  parameter int DECIM_LOG2 = 8,
  parameter int PCM_BITS   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clk_en,
  input  logic                       pdm_in,
  output logic signed [PCM_BITS-1:0] pcm_out,
  output logic                       pcm_valid,
  output logic                       pcm_clip
);

  localparam int W     = 3 * DECIM_LOG2 + 2;
  localparam int SHIFT = 3 * DECIM_LOG2 - 15;
  localparam int LSH   = (SHIFT < 0) ? -SHIFT : 0;
  localparam int RSH   = (SHIFT > 0) ? SHIFT : 0;
  localparam int SW    = W + LSH + 1;
  localparam logic [DECIM_LOG2-1:0] CNT_LAST = '1;

  logic pdm_bit;

`ifdef PDM_PCM_DECODER_INSYNC_EN
  logic sync1;
  logic sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pdm_in;
      sync2 <= sync1;
    end
  end

  assign pdm_bit = sync2;
`else
  assign pdm_bit = pdm_in;
`endif

  logic [W-1:0] x;
  logic [W-1:0] i1;
  logic [W-1:0] i2;
  logic [W-1:0] i3;

  assign x = pdm_bit ? W'(1) : '1;

  // Integrators wrap modulo 2^W by design; the comb differences undo the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1 <= '0;
      i2 <= '0;
      i3 <= '0;
    end else if (clk_en) begin
      i1 <= i1 + x;
      i2 <= i2 + i1;
      i3 <= i3 + i2;
    end
  end

  logic [DECIM_LOG2-1:0] cnt;
  logic                  dec_stb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      dec_stb <= 1'b0;
    end else begin
      dec_stb <= clk_en && (cnt == CNT_LAST);
      if (clk_en) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  logic [W-1:0] d1;
  logic [W-1:0] d2;
  logic [W-1:0] d3;
  logic [W-1:0] c1;
  logic [W-1:0] c2;
  logic [W-1:0] c3;
  logic         v1;
  logic         v2;
  logic         v3;

  // One comb stage per clk, clocked at full rate regardless of clk_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1 <= '0;
      d2 <= '0;
      d3 <= '0;
      c1 <= '0;
      c2 <= '0;
      c3 <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      v1 <= dec_stb;
      v2 <= v1;
      v3 <= v2;
      if (dec_stb) begin
        c1 <= i3 - d1;
        d1 <= i3;
      end
      if (v1) begin
        c2 <= c1 - d2;
        d2 <= c1;
      end
      if (v2) begin
        c3 <= c2 - d3;
        d3 <= c2;
      end
    end
  end

  logic signed [SW-1:0]       ext;
  logic signed [SW-1:0]       s;
  logic                       hi_zero;
  logic                       hi_one;
  logic                       sat;
  logic signed [PCM_BITS-1:0] sat_val;

  assign ext     = {{(SW-W){c3[W-1]}}, c3};
  assign s       = (ext <<< LSH) >>> RSH;
  assign hi_zero = ~|s[SW-1:PCM_BITS-1];
  assign hi_one  = &s[SW-1:PCM_BITS-1];
  assign sat     = !(hi_zero || hi_one);
  assign sat_val = s[SW-1] ? {1'b1, {(PCM_BITS-1){1'b0}}} : {1'b0, {(PCM_BITS-1){1'b1}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcm_out   <= '0;
      pcm_clip  <= 1'b0;
      pcm_valid <= 1'b0;
    end else begin
      pcm_valid <= v3;
      if (v3) begin
        pcm_out  <= sat ? sat_val : s[PCM_BITS-1:0];
        pcm_clip <= sat;
      end
    end
  end

endmodule

// File: tb/tb_pdm_pcm_decoder.sv
// tb/tb_pdm_pcm_decoder.sv - randomized bench for pdm_pcm_decoder against a closed-form CIC model
// Expected samples come from the triangular CIC kernel applied to the bits actually consumed.
module tb_pdm_pcm_decoder;

  localparam int R  = 256;
  localparam int W  = 26;
  localparam int SH = 9;

  logic               clk    = 1'b0;
  logic               rst_n  = 1'b0;
  logic               clk_en = 1'b0;
  logic               pdm_in = 1'b0;
  logic signed [15:0] pcm_out;
  logic               pcm_valid;
  logic               pcm_clip;

  int vectors = 0;
  int errors  = 0;

  pdm_pcm_decoder #(.DECIM_LOG2(8), .PCM_BITS(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_en    (clk_en),
    .pdm_in    (pdm_in),
    .pcm_out   (pcm_out),
    .pcm_valid (pcm_valid),
    .pcm_clip  (pcm_clip)
  );

  always #10 clk = ~clk;

  int          cyc = 0;
  int          bits[$];
  int          stb_cyc[$];
  logic [15:0] s_out[$];
  logic        s_clip[$];
  int          s_cyc[$];
  logic        h0 = 1'b0;
  logic        h1 = 1'b0;
  logic        mb;
  int          sd_acc;
  int          sd_lvl;

  // Record each consumed bit; every R-th one marks a decimation edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst_n) begin
`ifdef PDM_PCM_DECODER_INSYNC_EN
      mb = h1;
      h1 = h0;
      h0 = pdm_in;
`else
      mb = pdm_in;
`endif
      if (clk_en) begin
        bits.push_back(mb ? 1 : -1);
        if (bits.size() % R == 0) stb_cyc.push_back(cyc);
      end
    end else begin
      h0 = 1'b0;
      h1 = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (pcm_valid) begin
      s_out.push_back(pcm_out);
      s_clip.push_back(pcm_clip);
      s_cyc.push_back(cyc);
    end
  end

  function automatic longint i3_at(input int m);
    longint acc = 0;
    longint t;
    if (m <= 0) return 0;
    for (int j = 1; j <= m; j++) begin
      t = longint'(m - j);
      acc += longint'(bits[j-1]) * (t * (t - 1) / 2);
    end
    return acc;
  endfunction

  function automatic void model(input int n, output logic [15:0] o, output logic c);
    longint cc;
    longint sv;
    int     m = (n + 1) * R;
    cc = i3_at(m) - 3 * i3_at(m - R) + 3 * i3_at(m - 2 * R) - i3_at(m - 3 * R);
    cc = cc & ((64'sd1 <<< W) - 1);
    if (cc >= (64'sd1 <<< (W - 1))) cc -= (64'sd1 <<< W);
    sv = cc >>> SH;
    if (sv > 32767) begin
      o = 16'h7fff;
      c = 1'b1;
    end else if (sv < -32768) begin
      o = 16'h8000;
      c = 1'b1;
    end else begin
      o = sv[15:0];
      c = 1'b0;
    end
  endfunction

  function automatic logic gen_bit(input int mode, input int idx);
    logic b;
    case (mode)
      0: b = 1'b1;
      1: b = 1'b0;
      2: b = (idx % 2 == 0);
      3: b = (idx % 4 != 3);
      4: b = (idx % 4 == 0);
      5: begin
        b = (sd_acc >= 0);
        sd_acc += sd_lvl - (b ? 1000 : -1000);
      end
      default: b = 1'($urandom_range(0, 1));
    endcase
    return b;
  endfunction

  task automatic clear_logs();
    bits.delete();
    stb_cyc.delete();
    s_out.delete();
    s_clip.delete();
    s_cyc.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n  = 1'b0;
    clk_en = 1'b0;
    repeat (3) @(negedge clk);
    clear_logs();
    rst_n = 1'b1;
  endtask

  // period 0 gives a random clk_en pattern.
  task automatic run(input int nsamp, input int period, input int mode);
    int ph     = 0;
    int idx    = 0;
    int budget = nsamp * R * ((period == 0) ? 8 : period) + 400;
    sd_acc = 0;
    while (s_out.size() < nsamp && budget > 0) begin
      @(negedge clk);
      if (period == 0) begin
        clk_en = ($urandom_range(0, 2) == 0);
      end else begin
        clk_en = (ph == 0);
        ph = (ph + 1) % period;
      end
      if (clk_en) begin
        pdm_in = gen_bit(mode, idx);
        idx++;
      end
      budget--;
    end
    @(negedge clk);
    clk_en = 1'b0;
    if (s_out.size() < nsamp) begin
      vectors++;
      errors++;
      $display("FAIL run_timeout mode=%0d: got %0d samples, need %0d", mode, s_out.size(), nsamp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors += 3;
    if (pcm_out !== 16'sd0) begin errors++; $display("FAIL reset_pcm_out: got %h want 0000", pcm_out); end
    if (pcm_valid !== 1'b0) begin errors++; $display("FAIL reset_pcm_valid: got %b want 0", pcm_valid); end
    if (pcm_clip !== 1'b0) begin errors++; $display("FAIL reset_pcm_clip: got %b want 0", pcm_clip); end
    clear_logs();
    rst_n = 1'b1;
  endtask

  task automatic test_patterns();
    logic [15:0] eo;
    logic        ec;
    logic [15:0] co[5] = '{16'h7fff, 16'h8000, 16'h0000, 16'h4000, 16'hc000};
    logic        cc[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int mode = 0; mode < 5; mode++) begin
      do_reset();
      run((mode == 0) ? 8 : 6, 4, mode);
      for (int k = 0; k < s_out.size(); k++) begin
        model(k, eo, ec);
        vectors += 3;
        if (s_out[k] !== eo) begin errors++; $display("FAIL pat%0d_model_out k=%0d: got %h want %h", mode, k, s_out[k], eo); end
        if (s_clip[k] !== ec) begin errors++; $display("FAIL pat%0d_model_clip k=%0d: got %b want %b", mode, k, s_clip[k], ec); end
        if (s_cyc[k] !== stb_cyc[k] + 4) begin errors++; $display("FAIL pat%0d_latency k=%0d: got cyc %0d want %0d", mode, k, s_cyc[k], stb_cyc[k] + 4); end
        if (k >= 3) begin
          vectors += 2;
          if (s_out[k] !== co[mode]) begin errors++; $display("FAIL pat%0d_level k=%0d: got %h want %h", mode, k, s_out[k], co[mode]); end
          if (s_clip[k] !== cc[mode]) begin errors++; $display("FAIL pat%0d_clip k=%0d: got %b want %b", mode, k, s_clip[k], cc[mode]); end
        end
        if (k >= 1) begin
          vectors++;
          if (s_cyc[k] - s_cyc[k-1] !== 4 * R) begin errors++; $display("FAIL pat%0d_period k=%0d: got %0d want %0d", mode, k, s_cyc[k] - s_cyc[k-1], 4 * R); end
        end
      end
    end
  endtask

  task automatic test_random_stream();
    logic [15:0] eo;
    logic        ec;
    for (int mode = 5; mode < 7; mode++) begin
      do_reset();
      sd_lvl = int'($urandom_range(0, 1800)) - 900;
      run(6, 0, mode);
      vectors++;
      if (s_out.size() !== stb_cyc.size()) begin errors++; $display("FAIL rnd%0d_count: got %0d want %0d", mode, s_out.size(), stb_cyc.size()); end
      for (int k = 0; k < s_out.size() && k < stb_cyc.size(); k++) begin
        model(k, eo, ec);
        vectors += 3;
        if (s_out[k] !== eo) begin errors++; $display("FAIL rnd%0d_out k=%0d: got %h want %h", mode, k, s_out[k], eo); end
        if (s_clip[k] !== ec) begin errors++; $display("FAIL rnd%0d_clip k=%0d: got %b want %b", mode, k, s_clip[k], ec); end
        if (s_cyc[k] !== stb_cyc[k] + 4) begin errors++; $display("FAIL rnd%0d_latency k=%0d: got cyc %0d want %0d", mode, k, s_cyc[k], stb_cyc[k] + 4); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] eo;
    logic        ec;
    do_reset();
    run(8, 1, 6);
    for (int k = 0; k < s_out.size(); k++) begin
      model(k, eo, ec);
      vectors += 3;
      if (s_out[k] !== eo) begin errors++; $display("FAIL b2b_out k=%0d: got %h want %h", k, s_out[k], eo); end
      if (s_clip[k] !== ec) begin errors++; $display("FAIL b2b_clip k=%0d: got %b want %b", k, s_clip[k], ec); end
      if (s_cyc[k] !== stb_cyc[k] + 4) begin errors++; $display("FAIL b2b_latency k=%0d: got cyc %0d want %0d", k, s_cyc[k], stb_cyc[k] + 4); end
      if (k >= 1) begin
        vectors++;
        if (s_cyc[k] - s_cyc[k-1] !== R) begin errors++; $display("FAIL b2b_period k=%0d: got %0d want %0d", k, s_cyc[k] - s_cyc[k-1], R); end
      end
    end
  endtask

  task automatic test_idle_resume();
    logic [15:0] eo;
    logic        ec;
    int          n0 = s_out.size();
    clk_en = 1'b0;
    repeat (3000) @(negedge clk);
    vectors++;
    if (s_out.size() !== n0) begin errors++; $display("FAIL idle_no_valid: got %0d samples want %0d", s_out.size(), n0); end
    run(n0 + 3, 4, 6);
    for (int k = n0; k < s_out.size(); k++) begin
      model(k, eo, ec);
      vectors += 2;
      if (s_out[k] !== eo) begin errors++; $display("FAIL resume_out k=%0d: got %h want %h", k, s_out[k], eo); end
      if (s_cyc[k] !== stb_cyc[k] + 4) begin errors++; $display("FAIL resume_latency k=%0d: got cyc %0d want %0d", k, s_cyc[k], stb_cyc[k] + 4); end
    end
  endtask

  task automatic test_reset_midpipe();
    int          ph     = 0;
    int          budget = 8 * R * 4;
    logic [15:0] eo;
    logic        ec;
    do_reset();
    run(4, 4, 0);
    while (stb_cyc.size() < 5 && budget > 0) begin
      @(negedge clk);
      clk_en = (ph == 0);
      ph = (ph + 1) % 4;
      pdm_in = 1'b1;
      budget--;
    end
    clk_en = 1'b0;
    vectors++;
    if (stb_cyc.size() < 5) begin errors++; $display("FAIL midpipe_setup: got %0d strobes want 5", stb_cyc.size()); end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors += 3;
    if (pcm_out !== 16'sd0) begin errors++; $display("FAIL midpipe_out_cleared: got %h want 0000", pcm_out); end
    if (pcm_valid !== 1'b0) begin errors++; $display("FAIL midpipe_valid_cleared: got %b want 0", pcm_valid); end
    if (pcm_clip !== 1'b0) begin errors++; $display("FAIL midpipe_clip_cleared: got %b want 0", pcm_clip); end
    @(negedge clk);
    clear_logs();
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    vectors++;
    if (s_out.size() !== 0) begin errors++; $display("FAIL midpipe_aborted: got %0d samples want 0", s_out.size()); end
    run(1, 4, 6);
    vectors += 3;
    if (s_out.size() !== 1 || stb_cyc.size() !== 1) begin
      errors++;
      $display("FAIL midpipe_first_count: got %0d samples/%0d strobes want 1/1", s_out.size(), stb_cyc.size());
    end
    if (s_cyc.size() > 0 && stb_cyc.size() > 0 && s_cyc[0] !== stb_cyc[0] + 4) begin
      errors++;
      $display("FAIL midpipe_first_latency: got cyc %0d want %0d", s_cyc[0], stb_cyc[0] + 4);
    end
    if (s_out.size() > 0) begin
      model(0, eo, ec);
      if (s_out[0] !== eo) begin errors++; $display("FAIL midpipe_first_out: got %h want %h", s_out[0], eo); end
    end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_random_stream();
    test_back_to_back();
    test_idle_resume();
    test_reset_midpipe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
